// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types for the fetch front end
//
// Purpose: types shared by fetch_queue and fetch_fifo.
//   fetch_state_t : request tracking state of the fetch engine
//   fetch_entry_t : one queued instruction {pc, instr}
//   ibus_req_t    : instruction bus request {valid, addr}
//   ibus_resp_t   : instruction bus response {addr_ok, data_ok, data}
//   align_pc      : forces a target address onto a 4-byte boundary

package fetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    localparam logic [63:0] PC_STEP = 64'd4;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction queue for the fetch front end
//
// Purpose: DEPTH-entry circular buffer of fetch_entry_t with wrap-around
// read/write pointers. Flush empties the queue and overrides push/pop.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry at the tail (caller guarantees not full)
//   push_entry  : entry to write
//   pop         : drop the head entry (caller guarantees not empty)
//   flush       : empty the queue (pointers and count to zero)
//   head        : current head entry (registered storage)
//   count       : number of occupied entries

module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner, instruction bus master and decode queue
//
// Purpose: issues one instruction bus request at a time, buffers returned
// instructions in a fetch_fifo, and hands them to decode via valid/ready.
// A redirect flushes the queue and squashes any in-flight response.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   ireq           : bus request {valid, addr}, both registered
//   iresp          : bus response; data_ok and data are used
//   redirect_valid : one-cycle pulse, new fetch target + flush
//   redirect_pc    : redirect target (low two bits ignored)
//   out_valid      : queue head is valid for decode
//   out_ready      : decode accepts the head this cycle
//   out_pc         : PC of the head entry
//   out_instr      : instruction of the head entry
//   count          : number of occupied queue entries

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output ibus_req_t                  ireq,
    input  ibus_resp_t                 iresp,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   req_pc_q, req_pc_d;

    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   count_next;
    logic          slot_free;
    logic          unused_addr_ok;

    assign unused_addr_ok = iresp.addr_ok;

    // Decode never sees the head during a redirect, so no pop collides
    // with the flush.
    assign out_valid = (fifo_count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = (state_q == REQ) & iresp.data_ok & ~redirect_valid;

    assign push_entry = '{pc: req_pc_q, instr: iresp.data};

    // Issue credit: a request is only launched if its response is certain
    // to find a free slot, so a push can never hit a full queue.
    assign count_next = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign slot_free  = count_next < DEPTH_W;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            // req_pc is left alone: the bus address must hold until data_ok.
            fetch_pc_d = align_pc(redirect_pc);
            unique case (state_q)
                IDLE:    state_d = IDLE;
                REQ:     state_d = iresp.data_ok ? IDLE : DISCARD;
                DISCARD: state_d = iresp.data_ok ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (slot_free) begin
                        state_d  = REQ;
                        req_pc_d = fetch_pc_q;
                    end
                end
                REQ: begin
                    if (iresp.data_ok) begin
                        fetch_pc_d = req_pc_q + PC_STEP;
                        if (slot_free) begin
                            state_d  = REQ;
                            req_pc_d = req_pc_q + PC_STEP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (iresp.data_ok) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign ireq.valid = (state_q != IDLE);
    assign ireq.addr  = req_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (fifo_count)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign count     = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h8000_0000;
    localparam logic [31:0] XK    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_wait;
    int          model_cnt;
    int          pops;
    logic [63:0] exp_pc;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic dok, input logic rdy, input logic rv, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        iresp.addr_ok  = 1'b0;
        iresp.data_ok  = dok;
        iresp.data     = ireq.addr[31:0] ^ XK;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        iresp          = '0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ireq_valid", ireq.valid, 0);
        check("rst_ireq_addr", ireq.addr, RPC);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        reset     = 1'b1;
        resp_wait = 0;
        model_cnt = 0;
        pops      = 0;
        exp_pc    = RPC;
    endtask

    // Bus responder answers each request lat cycles after it appears;
    // every pop is checked against the expected sequential PC stream.
    task automatic run_stream(input int n, input int lat, input logic [31:0] rdy_pat, input bit gapless);
        logic dok;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dok = 1'b0;
            if (ireq.valid) begin
                if (resp_wait == lat) begin
                    dok       = 1'b1;
                    resp_wait = 0;
                end else begin
                    resp_wait++;
                end
            end
            iresp.data_ok  = dok;
            iresp.data     = ireq.addr[31:0] ^ XK;
            out_ready      = rdy_pat[i % 32];
            redirect_valid = 1'b0;
            #1;
            check("sb_count", count, model_cnt);
            check("sb_count_le_depth", count <= DEPTH, 1);
            if (gapless && i >= 1) check("stream_gapless", out_valid, 1);
            if (out_valid && out_ready) begin
                check("sb_pc", out_pc, exp_pc);
                check("sb_instr", out_instr, exp_pc[31:0] ^ XK);
                exp_pc = exp_pc + 64'd4;
                model_cnt--;
                pops++;
            end
            if (dok) model_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming, immediate response: one instruction per cycle.
        do_reset();
        run_stream(20, 0, 32'hFFFF_FFFF, 1'b1);
        check("stream0_pops", pops, 19);

        // Streaming, response one cycle after valid.
        do_reset();
        run_stream(24, 1, 32'hFFFF_FFFF, 1'b0);
        check("stream1_pops", pops, 11);

        // Backpressure: fills to DEPTH then stops issuing.
        do_reset();
        run_stream(6, 0, 32'h0, 1'b0);
        check("bp_count", count, 4);
        check("bp_ireq_valid", ireq.valid, 0);
        check("bp_head_pc", out_pc, RPC);
        drive(0, 1, 0, 0);
        check("bp_pop0_valid", out_valid, 1);
        check("bp_pop0_pc", out_pc, RPC);
        drive(0, 1, 0, 0);
        check("bp_resume_valid", ireq.valid, 1);
        check("bp_resume_addr", ireq.addr, RPC + 64'h10);
        check("bp_resume_count", count, 3);
        check("bp_pop1_pc", out_pc, RPC + 64'h4);
        // Continue with toggling ready: full+pop+issue and pointer wrap.
        exp_pc    = RPC + 64'h8;
        model_cnt = 2;
        pops      = 0;
        resp_wait = 0;
        run_stream(32, 0, 32'hFF00_F0CC, 1'b0);
        check("wrap_pops_ge_12", pops >= 12, 1);

        // Redirect while a request is in flight.
        do_reset();
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        check("rd_pop0_pc", out_pc, RPC);
        drive(0, 1, 1, 64'h8000_1002);
        check("rd_addr_at_redirect", ireq.addr, RPC + 64'h8);
        check("rd_out_valid_masked", out_valid, 0);
        drive(0, 1, 0, 0);
        check("rd_discard_valid", ireq.valid, 1);
        check("rd_discard_addr1", ireq.addr, RPC + 64'h8);
        check("rd_flush_count", count, 0);
        drive(0, 1, 0, 0);
        check("rd_discard_addr2", ireq.addr, RPC + 64'h8);
        drive(1, 1, 0, 0);
        check("rd_discard_addr3", ireq.addr, RPC + 64'h8);
        drive(0, 1, 0, 0);
        check("rd_idle_valid", ireq.valid, 0);
        check("rd_dropped_count", count, 0);
        check("rd_dropped_out_valid", out_valid, 0);
        drive(1, 1, 0, 0);
        check("rd_new_valid", ireq.valid, 1);
        check("rd_new_addr", ireq.addr, 64'h8000_1000);
        drive(0, 1, 0, 0);
        check("rd_first_out_valid", out_valid, 1);
        check("rd_first_out_pc", out_pc, 64'h8000_1000);
        check("rd_first_out_instr", out_instr, 32'h8000_1000 ^ XK);

        // Redirect in the same cycle as data_ok.
        do_reset();
        drive(1, 1, 1, 64'h8000_2000);
        check("co_req_valid", ireq.valid, 1);
        check("co_out_valid", out_valid, 0);
        drive(0, 1, 0, 0);
        check("co_idle_valid", ireq.valid, 0);
        check("co_no_push", count, 0);
        check("co_no_out", out_valid, 0);
        drive(1, 1, 0, 0);
        check("co_new_valid", ireq.valid, 1);
        check("co_new_addr", ireq.addr, 64'h8000_2000);
        drive(0, 1, 0, 0);
        check("co_first_valid", out_valid, 1);
        check("co_first_pc", out_pc, 64'h8000_2000);
        check("co_first_count", count, 1);

        // Asynchronous reset mid-request with two entries queued.
        do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("ar_pre_count", count, 2);
        check("ar_pre_valid", ireq.valid, 1);
        check("ar_pre_addr", ireq.addr, RPC + 64'h8);
        #1;
        reset = 1'b0;
        #1;
        check("ar_valid_drop", ireq.valid, 0);
        check("ar_out_valid_drop", out_valid, 0);
        check("ar_count_drop", count, 0);
        check("ar_addr_reset", ireq.addr, RPC);
        drive(1, 0, 0, 0);
        check("ar_held_count", count, 0);
        drive(0, 0, 0, 0);
        check("ar_no_capture", count, 0);
        check("ar_held_valid", ireq.valid, 0);
        #2;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        check("ar_restart_valid", ireq.valid, 1);
        check("ar_restart_addr", ireq.addr, RPC);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("ar_restart_out_valid", out_valid, 1);
        check("ar_restart_out_pc", out_pc, RPC);
        check("ar_restart_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
